// File: rtl/alu_drv_pkg.sv
// Shared definitions for the ALU command driver: FSM state encoding and default widths.
package alu_drv_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefFunW  = 3;

    typedef enum logic {
        StIdle,
        StWait
    } drv_state_e;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command and result handshake bundle between a command issuer and alu_cmd_driver.
// master = issuer/consumer side, slave = the driver.
interface alu_cmd_driver_if
    import alu_drv_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned FUN_W = DefFunW
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [FUN_W-1:0] cmd_fun;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_y;
    logic [FUN_W-1:0] res_fun;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_fun, res_ready,
        input  cmd_ready, res_valid, res_y, res_fun
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_fun, res_ready,
        output cmd_ready, res_valid, res_y, res_fun
    );

endinterface

// File: rtl/alu_res_fifo.sv
// Synchronous result FIFO with first-word fall-through head and occupancy count.
// When empty, the data output holds the last popped word (zero after reset).
module alu_res_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 35,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [DW-1:0]   i_push_data,
    input  logic            i_pop,
    output logic            o_valid,
    output logic [DW-1:0]   o_data,
    output logic [CntW-1:0] o_count
);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic [DW-1:0]   r_last;
    logic            w_pop;

    // Pops on an empty FIFO are ignored; the caller never pushes when full.
    assign w_pop = i_pop && (r_count != '0);

    // Storage array: written on push, no reset needed since reads are gated by count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and the held copy of the last popped word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : r_last;
    assign o_count = r_count;

endmodule

// File: rtl/alu_cmd_driver.sv
// Back-pressured command issuer for a 32-bit ALU: registers an accepted command onto the
// ALU inputs, samples alu_y ALU_LAT edges later and queues {y, fun} in a result FIFO.
// Optional self-check (exp/chk per command, err_flag/err_count) under ALU_DRV_CHECK_EN.
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned FUN_W   = DefFunW,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_driver_if.slave    if_bus,
    output logic [WIDTH-1:0]   o_alu_a,
    output logic [WIDTH-1:0]   o_alu_b,
    output logic [FUN_W-1:0]   o_alu_fun,
    input  logic [WIDTH-1:0]   i_alu_y,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_op_count
`ifdef ALU_DRV_CHECK_EN
    ,
    input  logic [WIDTH-1:0]   i_cmd_exp,
    input  logic               i_cmd_chk,
    output logic               o_err_flag,
    output logic [CNT_W-1:0]   o_err_count
`endif
);

    localparam int unsigned LatW     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam int unsigned FifoCntW = $clog2(DEPTH) + 1;
    localparam logic [FifoCntW-1:0] FifoFull = FifoCntW'(DEPTH);
    localparam logic [LatW-1:0]     LatLoad  = LatW'(ALU_LAT - 1);

    drv_state_e              r_state;
    logic [LatW-1:0]         r_cnt;
    logic [WIDTH-1:0]        r_alu_a;
    logic [WIDTH-1:0]        r_alu_b;
    logic [FUN_W-1:0]        r_alu_fun;
    logic [CNT_W-1:0]        r_op_count;
    logic                    w_cmd_ready;
    logic                    w_accept;
    logic                    w_sample;
    logic [FifoCntW-1:0]     w_fifo_count;
    logic [WIDTH+FUN_W-1:0]  w_head;
`ifdef ALU_DRV_CHECK_EN
    logic [WIDTH-1:0]        r_exp;
    logic                    r_chk;
    logic                    r_err_flag;
    logic [CNT_W-1:0]        r_err_count;
`endif

    // Space is reserved at accept time, so the in-flight op can always push.
    assign w_cmd_ready = (r_state == StIdle) && (w_fifo_count < FifoFull);
    assign w_accept    = if_bus.cmd_valid && w_cmd_ready;
    assign w_sample    = (r_state == StWait) && (r_cnt == '0);

    // Issue FSM: latch command onto ALU inputs, count settle latency, sample and push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_fun  <= '0;
            r_op_count <= '0;
`ifdef ALU_DRV_CHECK_EN
            r_exp       <= '0;
            r_chk       <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_count <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_alu_a   <= if_bus.cmd_a;
                        r_alu_b   <= if_bus.cmd_b;
                        r_alu_fun <= if_bus.cmd_fun;
                        r_cnt     <= LatLoad;
                        r_state   <= StWait;
`ifdef ALU_DRV_CHECK_EN
                        r_exp <= i_cmd_exp;
                        r_chk <= i_cmd_chk;
`endif
                    end
                end
                StWait: begin
                    if (r_cnt == '0) begin
                        r_op_count <= r_op_count + 1'b1;
                        r_state    <= StIdle;
`ifdef ALU_DRV_CHECK_EN
                        if (r_chk && (i_alu_y != r_exp)) begin
                            r_err_flag <= 1'b1;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + 1'b1;
                            end
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    alu_res_fifo #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + FUN_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_sample),
        .i_push_data ({i_alu_y, r_alu_fun}),
        .i_pop       (if_bus.res_ready),
        .o_valid     (if_bus.res_valid),
        .o_data      (w_head),
        .o_count     (w_fifo_count)
    );

    assign if_bus.cmd_ready = w_cmd_ready;
    assign if_bus.res_y     = w_head[FUN_W +: WIDTH];
    assign if_bus.res_fun   = w_head[FUN_W-1:0];

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_fun  = r_alu_fun;
    assign o_busy     = (r_state == StWait);
    assign o_op_count = r_op_count;
`ifdef ALU_DRV_CHECK_EN
    assign o_err_flag  = r_err_flag;
    assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural single-cycle ALU (fun 000 = a+b).
// Self-check ports are exercised when ALU_DRV_CHECK_EN is defined.
module tb_alu_cmd_driver;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_fun;
    logic [31:0] alu_y;
    logic        busy;
    logic [15:0] op_count;
`ifdef ALU_DRV_CHECK_EN
    logic [31:0] cmd_exp;
    logic        cmd_chk;
    logic        err_flag;
    logic [15:0] err_count;
`endif

    int n_pass;
    int n_fail;
    int n_total;

    logic [31:0] t3_a [5];
    logic [31:0] t3_b [5];
    logic [2:0]  t3_f [5];
    logic [31:0] t3_y [5];

    alu_cmd_driver_if #(.WIDTH(32), .FUN_W(3)) bus ();

    alu_cmd_driver #(
        .WIDTH   (32),
        .FUN_W   (3),
        .ALU_LAT (1),
        .DEPTH   (4),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_bus      (bus),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_fun   (alu_fun),
        .i_alu_y     (alu_y),
        .o_busy      (busy),
        .o_op_count  (op_count)
`ifdef ALU_DRV_CHECK_EN
        ,
        .i_cmd_exp   (cmd_exp),
        .i_cmd_chk   (cmd_chk),
        .o_err_flag  (err_flag),
        .o_err_count (err_count)
`endif
    );

    // Behavioural ALU standing in for the real one.
    always_comb begin
        alu_y = '0;
        case (alu_fun)
            3'd0: alu_y = alu_a + alu_b;
            3'd1: alu_y = alu_a - alu_b;
            3'd2: alu_y = alu_a & alu_b;
            3'd3: alu_y = alu_a | alu_b;
            3'd4: alu_y = alu_a ^ alu_b;
            default: alu_y = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return just after the edge that accepted it.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        int k;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_fun   = f;
        bus.cmd_valid = 1'b1;
        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            step();
            k++;
        end
        check("send_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int acc_idx;
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        t3_a = '{32'h1, 32'hA, 32'hF0, 32'hF0, 32'hAA};
        t3_b = '{32'h2, 32'h3, 32'h3C, 32'h0F, 32'hFF};
        t3_f = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        t3_y = '{32'h3, 32'h7, 32'h30, 32'hFF, 32'h55};

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_fun   = '0;
        bus.res_ready = 1'b0;
`ifdef ALU_DRV_CHECK_EN
        cmd_exp = '0;
        cmd_chk = 1'b0;
`endif
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_res_y", bus.res_y, 32'd0);
        step();
        step();
        rst = 1'b0;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // 1: reset while an op is in flight
        bus.res_ready = 1'b1;
        send(32'h10, 32'h110, 3'd0);
        check("t1_busy_before", 32'(busy), 32'd1);
        check("t1_alu_a_before", alu_a, 32'h10);
        #2;
        rst = 1'b1;
        #1;
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_res_valid", 32'(bus.res_valid), 32'd0);
        check("t1_op_count", 32'(op_count), 32'd0);
        check("t1_alu_a", alu_a, 32'd0);
        #1;
        rst = 1'b0;
        step();
        check("t1_dropped", 32'(bus.res_valid), 32'd0);

        // 2: single op, accept -> result one edge later
        send(32'h10, 32'h110, 3'd0);
        check("t2_alu_a", alu_a, 32'h10);
        check("t2_alu_b", alu_b, 32'h110);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_res_valid_early", 32'(bus.res_valid), 32'd0);
        step();
        check("t2_res_valid", 32'(bus.res_valid), 32'd1);
        check("t2_res_y", bus.res_y, 32'h120);
        check("t2_res_fun", 32'(bus.res_fun), 32'd0);
        check("t2_op_count", 32'(op_count), 32'd1);
        check("t2_idle", 32'(busy), 32'd0);
        step();
        check("t2_popped", 32'(bus.res_valid), 32'd0);
        check("t2_hold_y", bus.res_y, 32'h120);

        // 3: fill the FIFO under back-pressure, then drain in order
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int k;
            bus.cmd_a     = t3_a[i];
            bus.cmd_b     = t3_b[i];
            bus.cmd_fun   = t3_f[i];
            bus.cmd_valid = 1'b1;
            k = 0;
            while (!bus.cmd_ready && k < 50) begin
                step();
                k++;
            end
            check("t3_fill_ready", 32'(bus.cmd_ready), 32'd1);
            step();
        end
        bus.cmd_a   = t3_a[4];
        bus.cmd_b   = t3_b[4];
        bus.cmd_fun = t3_f[4];
        step();
        check("t3_full_ready", 32'(bus.cmd_ready), 32'd0);
        check("t3_full_count", 32'(dut.w_fifo_count), 32'd4);
        check("t3_full_op_count", 32'(op_count), 32'd5);
        step();
        step();
        check("t3_full_ready_hold", 32'(bus.cmd_ready), 32'd0);
        bus.res_ready = 1'b1;
        acc_idx = -1;
        for (int j = 0; j < 5; j++) begin
            check("t3_drain_valid", 32'(bus.res_valid), 32'd1);
            check("t3_drain_y", bus.res_y, t3_y[j]);
            check("t3_drain_fun", 32'(bus.res_fun), 32'(t3_f[j]));
            if (bus.cmd_valid && bus.cmd_ready) acc_idx = j;
            step();
            if (acc_idx == j) bus.cmd_valid = 1'b0;
        end
        check("t3_fifth_accept_slot", 32'(acc_idx), 32'd1);
        check("t3_empty", 32'(bus.res_valid), 32'd0);
        check("t3_op_count", 32'(op_count), 32'd6);

        // 4: continuous valid with free consumer -> one accept every two cycles
        bus.cmd_a     = 32'h3;
        bus.cmd_b     = 32'h4;
        bus.cmd_fun   = 3'd0;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t4_busy", 32'(busy), 32'(k % 2));
            check("t4_ready", 32'(bus.cmd_ready), 32'((k + 1) % 2));
            step();
        end
        bus.cmd_valid = 1'b0;
        check("t4_op_count", 32'(op_count), 32'd10);
        check("t4_res_y", bus.res_y, 32'h7);
        step();

        // 5: FIFO at two entries, push and pop on the same edge
        bus.res_ready = 1'b0;
        send(32'h100, 32'h23, 3'd0);
        step();
        send(32'h5, 32'h7, 3'd1);
        step();
        check("t5_count_pre", 32'(dut.w_fifo_count), 32'd2);
        check("t5_head_pre", bus.res_y, 32'h123);
        send(32'h0F0F, 32'h00FF, 3'd4);
        bus.res_ready = 1'b1;
        step();
        check("t5_count_same", 32'(dut.w_fifo_count), 32'd2);
        check("t5_head_adv", bus.res_y, 32'hFFFF_FFFE);
        check("t5_head_fun", 32'(bus.res_fun), 32'd1);
        check("t5_op_count", 32'(op_count), 32'd13);
        step();
        check("t5_last_y", bus.res_y, 32'h0FF0);
        check("t5_last_fun", 32'(bus.res_fun), 32'd4);
        step();
        check("t5_empty", 32'(bus.res_valid), 32'd0);
        check("t5_hold_y", bus.res_y, 32'h0FF0);

`ifdef ALU_DRV_CHECK_EN
        // 6: result self-check
        check("t6_flag_init", 32'(err_flag), 32'd0);
        cmd_chk = 1'b1;
        cmd_exp = 32'h121;
        send(32'h10, 32'h110, 3'd0);
        step();
        check("t6_flag", 32'(err_flag), 32'd1);
        check("t6_count", 32'(err_count), 32'd1);
        cmd_chk = 1'b0;
        cmd_exp = 32'h0;
        send(32'h10, 32'h110, 3'd0);
        step();
        check("t6_nochk_count", 32'(err_count), 32'd1);
        cmd_chk = 1'b1;
        cmd_exp = 32'h120;
        send(32'h10, 32'h110, 3'd0);
        step();
        check("t6_match_count", 32'(err_count), 32'd1);
        check("t6_flag_sticky", 32'(err_flag), 32'd1);
        check("t6_op_count", 32'(op_count), 32'd16);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
